// File: rtl/pipelined_processor.sv
// Five-stage in-order RV32I-subset core (add/sub/and/or/slt, I-type ALU, lw/sw, beq, jal)
// with internal instruction ROM, data RAM and register file; EX-stage forwarding and branch resolve.
module pipelined_processor #(
  parameter string IMEM_FILE  = "program.hex",
  parameter int    IMEM_DEPTH = 64,
  parameter int    DMEM_DEPTH = 64
) (
  input logic i_Clk,
  input logic i_Reset
);
  localparam int IA = $clog2(IMEM_DEPTH);
  localparam int DA = $clog2(DMEM_DEPTH);

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_e;
  typedef struct packed {
    logic we;
    logic mem_re;
    logic mem_we;
    logic beq;
    logic jal;
    logic use_imm;
    alu_e op;
  } ctrl_t;

  logic [31:0] imem   [IMEM_DEPTH];
  logic [31:0] dmem_q [DMEM_DEPTH] = '{default: '0};
  logic [31:0] rf_q   [32];

  // vld_q[1]=IF/ID, [2]=ID/EX, [3]=EX/MEM, [4]=MEM/WB
  logic [4:1]  vld_q;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_q, ifid_ir_q;
  ctrl_t       idex_ctrl_q;
  logic [31:0] idex_pc_q, idex_a_q, idex_b_q, idex_imm_q;
  logic [4:0]  idex_rs1_q, idex_rs2_q, idex_rd_q;
  logic        exmem_we_q, exmem_re_q, exmem_st_q;
  logic [4:0]  exmem_rd_q;
  logic [31:0] exmem_res_q, exmem_sd_q;
  logic        memwb_we_q;
  logic [4:0]  memwb_rd_q;
  logic [31:0] memwb_data_q;

  // ---------------- ID ----------------
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  ctrl_t       id_ctrl;
  logic [31:0] id_imm, id_a, id_b;
  logic        wb_we;

  assign opc    = ifid_ir_q[6:0];
  assign f3     = ifid_ir_q[14:12];
  assign id_rd  = ifid_ir_q[11:7];
  assign id_rs1 = ifid_ir_q[19:15];
  assign id_rs2 = ifid_ir_q[24:20];
  assign wb_we  = vld_q[4] & memwb_we_q & (memwb_rd_q != 5'd0);

  always_comb begin
    id_ctrl    = '0;
    id_ctrl.op = ALU_ADD;
    id_imm     = {{20{ifid_ir_q[31]}}, ifid_ir_q[31:20]};
    case (opc)
      7'b0110011, 7'b0010011: begin
        id_ctrl.we      = 1'b1;
        id_ctrl.use_imm = opc[5] == 1'b0;
        case (f3)
          3'b000:  id_ctrl.op = (opc[5] && ifid_ir_q[30]) ? ALU_SUB : ALU_ADD;
          3'b111:  id_ctrl.op = ALU_AND;
          3'b110:  id_ctrl.op = ALU_OR;
          3'b010:  id_ctrl.op = ALU_SLT;
          default: id_ctrl.we = 1'b0;
        endcase
      end
      7'b0000011: begin
        id_ctrl.we      = 1'b1;
        id_ctrl.mem_re  = 1'b1;
        id_ctrl.use_imm = 1'b1;
      end
      7'b0100011: begin
        id_ctrl.mem_we  = 1'b1;
        id_ctrl.use_imm = 1'b1;
        id_imm = {{20{ifid_ir_q[31]}}, ifid_ir_q[31:25], ifid_ir_q[11:7]};
      end
      7'b1100011: begin
        id_ctrl.beq = (f3 == 3'b000);
        id_imm = {{19{ifid_ir_q[31]}}, ifid_ir_q[31], ifid_ir_q[7],
                  ifid_ir_q[30:25], ifid_ir_q[11:8], 1'b0};
      end
      7'b1101111: begin
        id_ctrl.we  = 1'b1;
        id_ctrl.jal = 1'b1;
        id_imm = {{11{ifid_ir_q[31]}}, ifid_ir_q[31], ifid_ir_q[19:12],
                  ifid_ir_q[20], ifid_ir_q[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  // Write-through: a WB write to the register being read is visible in the same cycle
  assign id_a = (id_rs1 == 5'd0) ? '0 : (wb_we && memwb_rd_q == id_rs1) ? memwb_data_q : rf_q[id_rs1];
  assign id_b = (id_rs2 == 5'd0) ? '0 : (wb_we && memwb_rd_q == id_rs2) ? memwb_data_q : rf_q[id_rs2];

  // ---------------- EX ----------------
  logic        mem_fwd;
  logic [31:0] op_a, op_b, alu_b, alu, ex_res, target;
  logic        redirect, load_use, stall;

  assign mem_fwd = vld_q[3] & exmem_we_q & (exmem_rd_q != 5'd0);
  assign op_a = (mem_fwd && exmem_rd_q == idex_rs1_q) ? exmem_res_q :
                (wb_we && memwb_rd_q == idex_rs1_q)   ? memwb_data_q : idex_a_q;
  assign op_b = (mem_fwd && exmem_rd_q == idex_rs2_q) ? exmem_res_q :
                (wb_we && memwb_rd_q == idex_rs2_q)   ? memwb_data_q : idex_b_q;
  assign alu_b = idex_ctrl_q.use_imm ? idex_imm_q : op_b;

  always_comb begin
    alu = op_a + alu_b;
    case (idex_ctrl_q.op)
      ALU_SUB: alu = op_a - alu_b;
      ALU_AND: alu = op_a & alu_b;
      ALU_OR:  alu = op_a | alu_b;
      ALU_SLT: alu = {31'b0, $signed(op_a) < $signed(alu_b)};
      default: ;
    endcase
  end

  assign ex_res   = idex_ctrl_q.jal ? idex_pc_q + 32'd4 : alu;
  assign target   = idex_pc_q + idex_imm_q;
  assign redirect = vld_q[2] & (idex_ctrl_q.jal | (idex_ctrl_q.beq & (op_a == op_b)));
  assign load_use = vld_q[2] & idex_ctrl_q.mem_re & (idex_rd_q != 5'd0) &
                    ((idex_rd_q == id_rs1) | (idex_rd_q == id_rs2));
  // A redirect squashes the stalled instruction anyway, so the flush takes priority
  assign stall    = load_use & ~redirect;
  assign pc_d     = redirect ? target : stall ? pc_q : pc_q + 32'd4;

  // ---------------- pipeline registers ----------------
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      pc_q <= '0; vld_q <= '0;
      ifid_pc_q <= '0; ifid_ir_q <= '0;
      idex_ctrl_q <= '0; idex_pc_q <= '0; idex_a_q <= '0; idex_b_q <= '0; idex_imm_q <= '0;
      idex_rs1_q <= '0; idex_rs2_q <= '0; idex_rd_q <= '0;
      exmem_we_q <= 1'b0; exmem_re_q <= 1'b0; exmem_st_q <= 1'b0;
      exmem_rd_q <= '0; exmem_res_q <= '0; exmem_sd_q <= '0;
      memwb_we_q <= 1'b0; memwb_rd_q <= '0; memwb_data_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (redirect) vld_q[1] <= 1'b0;
      else if (!stall) begin
        vld_q[1]  <= 1'b1;
        ifid_pc_q <= pc_q;
        ifid_ir_q <= imem[pc_q[IA+1:2]];
      end
      vld_q[2]    <= vld_q[1] & ~redirect & ~stall;
      idex_ctrl_q <= id_ctrl;
      idex_pc_q   <= ifid_pc_q;
      idex_a_q    <= id_a;
      idex_b_q    <= id_b;
      idex_imm_q  <= id_imm;
      idex_rs1_q  <= id_rs1;
      idex_rs2_q  <= id_rs2;
      idex_rd_q   <= id_rd;
      vld_q[3]    <= vld_q[2];
      exmem_we_q  <= idex_ctrl_q.we;
      exmem_re_q  <= idex_ctrl_q.mem_re;
      exmem_st_q  <= idex_ctrl_q.mem_we;
      exmem_rd_q  <= idex_rd_q;
      exmem_res_q <= ex_res;
      exmem_sd_q  <= op_b;
      vld_q[4]     <= vld_q[3];
      memwb_we_q   <= exmem_we_q;
      memwb_rd_q   <= exmem_rd_q;
      memwb_data_q <= exmem_re_q ? dmem_q[exmem_res_q[DA+1:2]] : exmem_res_q;
    end
  end

  always_ff @(posedge i_Clk)
    if (vld_q[3] && exmem_st_q) dmem_q[exmem_res_q[DA+1:2]] <= exmem_sd_q;

  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_we) begin
      rf_q[memwb_rd_q] <= memwb_data_q;
    end
  end
endmodule

// File: tb/tb_pipelined_processor.sv
// Directed program bench: loads a hand-assembled program and checks architectural state at fixed edges.
module tb_pipelined_processor;
  logic i_Clk   = 1'b0;
  logic i_Reset = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;

  pipelined_processor #(.IMEM_FILE(""), .IMEM_DEPTH(64), .DMEM_DEPTH(64)) dut (
    .i_Clk  (i_Clk),
    .i_Reset(i_Reset)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to rising edge e after reset release, then sample 1ns later
  task automatic step_to(input int e);
    repeat (e - cyc) @(posedge i_Clk);
    cyc = e;
    #1;
  endtask

  logic [31:0] prog [22];

  initial begin
    prog = '{
      32'h00500093,  // 00 addi x1,x0,5
      32'h00700113,  // 04 addi x2,x0,7
      32'h002081B3,  // 08 add  x3,x1,x2
      32'h40118233,  // 0C sub  x4,x3,x1
      32'h008000EF,  // 10 jal  x1,+8
      32'h00100513,  // 14 addi x10,x0,1  (skipped)
      32'h00500093,  // 18 addi x1,x0,5
      32'h00208463,  // 1C beq  x1,x2,+8  (not taken)
      32'h00300593,  // 20 addi x11,x0,3
      32'h00000663,  // 24 beq  x0,x0,+12 (taken)
      32'h00100313,  // 28 addi x6,x0,1   (skipped)
      32'h00100393,  // 2C addi x7,x0,1   (skipped)
      32'h00900013,  // 30 addi x0,x0,9
      32'h0020A433,  // 34 slt  x8,x1,x2
      32'hFFF0A613,  // 38 slti x12,x1,-1
      32'h0020F6B3,  // 3C and  x13,x1,x2
      32'h0020E733,  // 40 or   x14,x1,x2
      32'h00C00193,  // 44 addi x3,x0,12
      32'h00302423,  // 48 sw   x3,8(x0)
      32'h00802203,  // 4C lw   x4,8(x0)
      32'h004202B3,  // 50 add  x5,x4,x4
      32'h0000006F   // 54 jal  x0,0
    };
    for (int i = 0; i < 64; i++) dut.imem[i] = (i < 22) ? prog[i] : 32'h0;

    #1;
    chk("reset_pc", dut.pc_q, 32'h0);
    chk("reset_x1", dut.rf_q[1], 32'h0);
    repeat (2) @(negedge i_Clk);
    i_Reset = 1'b1;
    cyc = 0;

    step_to(6);  chk("fwd_x3_before", dut.rf_q[3], 32'd0);
    step_to(7);  chk("fwd_x3_edge7", dut.rf_q[3], 32'd12);
    step_to(8);  chk("fwd_x4_sub", dut.rf_q[4], 32'd7);
    step_to(10); chk("jal_link_x1", dut.rf_q[1], 32'h14);
    step_to(22); chk("or_x14", dut.rf_q[14], 32'd7);
                 chk("dmem2_before_sw", dut.dmem_q[2], 32'd0);
    step_to(23); chk("dmem2_after_sw", dut.dmem_q[2], 32'd12);
    step_to(26); chk("lw_x4", dut.rf_q[4], 32'd12);
                 chk("loaduse_x5_not_yet", dut.rf_q[5], 32'd0);
    step_to(27); chk("loaduse_x5", dut.rf_q[5], 32'd24);
    step_to(30);
    chk("x0_zero", dut.rf_q[0], 32'd0);
    chk("x1_final", dut.rf_q[1], 32'd5);
    chk("x2_final", dut.rf_q[2], 32'd7);
    chk("x3_final", dut.rf_q[3], 32'd12);
    chk("beq_skip_x6", dut.rf_q[6], 32'd0);
    chk("beq_skip_x7", dut.rf_q[7], 32'd0);
    chk("slt_x8", dut.rf_q[8], 32'd1);
    chk("jal_skip_x10", dut.rf_q[10], 32'd0);
    chk("beq_fall_x11", dut.rf_q[11], 32'd3);
    chk("slti_neg_x12", dut.rf_q[12], 32'd0);
    chk("and_x13", dut.rf_q[13], 32'd5);

    // Mid-run reset for one cycle
    @(negedge i_Clk);
    i_Reset = 1'b0;
    #1;
    chk("mrst_pc", dut.pc_q, 32'h0);
    chk("mrst_x5", dut.rf_q[5], 32'd0);
    chk("mrst_x1", dut.rf_q[1], 32'd0);
    chk("mrst_dmem2", dut.dmem_q[2], 32'd12);
    @(negedge i_Clk);
    i_Reset = 1'b1;
    cyc = 0;

    step_to(6);  chk("rerun_x3_before", dut.rf_q[3], 32'd0);
    step_to(7);  chk("rerun_x3_edge7", dut.rf_q[3], 32'd12);
    step_to(26); chk("rerun_x5_not_yet", dut.rf_q[5], 32'd0);
    step_to(40);
    chk("rerun_x5", dut.rf_q[5], 32'd24);
    chk("rerun_x4", dut.rf_q[4], 32'd12);
    chk("rerun_x8", dut.rf_q[8], 32'd1);
    chk("rerun_x6", dut.rf_q[6], 32'd0);
    chk("rerun_x11", dut.rf_q[11], 32'd3);
    chk("rerun_x14", dut.rf_q[14], 32'd7);
    chk("rerun_dmem2", dut.dmem_q[2], 32'd12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
